// File: rtl/gate_tt_sequencer.sv
// Self-test sequencer for a 2-input combinational gate: sweeps a/b through 00..11,
// captures c after a programmable settle time and compares against an expected table.
module gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] exp_tt,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result_tt,
  output logic [3:0] mismatch,
  output logic       aborted
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_tt_sequencer: SETTLE_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       vec, vec_nxt, vec_inc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       tt, tt_nxt;
  logic [3:0]       exp_q, exp_nxt;
  logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt, aborted_nxt;
  logic [3:0]       result_nxt, mismatch_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= '0;
      cnt       <= '0;
      tt        <= '0;
      exp_q     <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      result_tt <= '0;
      mismatch  <= '0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      cnt       <= cnt_nxt;
      tt        <= tt_nxt;
      exp_q     <= exp_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      result_tt <= result_nxt;
      mismatch  <= mismatch_nxt;
      aborted   <= aborted_nxt;
    end
  end

  assign vec_inc = vec + 2'd1;

  // Next-state and next-output logic; outputs change on the same edge as the state
  always_comb begin
    state_nxt    = state;
    vec_nxt      = vec;
    cnt_nxt      = cnt;
    tt_nxt       = tt;
    exp_nxt      = exp_q;
    a_nxt        = a;
    b_nxt        = b;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    aborted_nxt  = 1'b0;
    pass_nxt     = pass;
    result_nxt   = result_tt;
    mismatch_nxt = mismatch;

    case (state)
      ST_IDLE: begin
        a_nxt    = 1'b0;
        b_nxt    = 1'b0;
        busy_nxt = 1'b0;
        if (start && !abort) begin
          exp_nxt   = exp_tt;
          tt_nxt    = '0;
          vec_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_nxt   = ST_IDLE;
          a_nxt       = 1'b0;
          b_nxt       = 1'b0;
          busy_nxt    = 1'b0;
          aborted_nxt = 1'b1;
          vec_nxt     = '0;
          cnt_nxt     = '0;
          tt_nxt      = '0;
        end else if (cnt == CNT_LAST) begin
          tt_nxt[vec] = c;
          cnt_nxt     = '0;
          if (vec == 2'd3) begin
            state_nxt = ST_DONE;
            a_nxt     = 1'b0;
            b_nxt     = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            vec_nxt = vec_inc;
            a_nxt   = vec_inc[1];
            b_nxt   = vec_inc[0];
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        a_nxt        = 1'b0;
        b_nxt        = 1'b0;
        busy_nxt     = 1'b0;
        result_nxt   = tt;
        mismatch_nxt = tt ^ exp_q;
        pass_nxt     = (tt == exp_q);
        state_nxt    = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        a_nxt     = 1'b0;
        b_nxt     = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench for gate_tt_sequencer: AND/OR gate models, settle 2 and settle 1 instances.
module tb_gate_tt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start0, abort0, c0, a0, b0, busy0, done0, pass0, aborted0;
  logic [3:0] exp0, res0, mm0;
  logic       gate_or0;

  logic       start1, abort1, c1, a1, b1, busy1, done1, pass1, aborted1;
  logic [3:0] exp1, res1, mm1;

  int checks = 0;
  int failures = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  logic [8:0] sb0[$];
  logic [8:0] sb1[$];

  logic [3:0] last_res0;
  logic [3:0] last_mm0;
  logic       last_pass0;

  always #5 clk = ~clk;

  assign c0 = gate_or0 ? (a0 | b0) : (a0 & b0);
  assign c1 = a1 | b1;

  gate_tt_sequencer #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .exp_tt(exp0), .c(c0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0), .result_tt(res0),
    .mismatch(mm0), .aborted(aborted0)
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .exp_tt(exp1), .c(c1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1), .result_tt(res1),
    .mismatch(mm1), .aborted(aborted1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {result_tt, mismatch, pass} from an independent gate model
  function automatic logic [8:0] sweep_expect(input logic [3:0] e, input bit is_or);
    logic [3:0] r;
    logic [1:0] kv;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      kv = 2'(k);
      r[k] = is_or ? (kv[1] | kv[0]) : (kv[1] & kv[0]);
    end
    return {r, r ^ e, r == e};
  endfunction

  // Scoreboard monitors: on done, compare the results visible one cycle later
  bit pend0 = 0;
  always @(negedge clk) begin
    logic [8:0] x;
    if (pend0) begin
      pend0 = 0;
      check_eq("sb0_pending", 32'(sb0.size() > 0), 32'd1);
      if (sb0.size() > 0) begin
        x = sb0.pop_front();
        check_eq("sb0_result_tt", 32'(res0), 32'(x[8:5]));
        check_eq("sb0_mismatch", 32'(mm0), 32'(x[4:1]));
        check_eq("sb0_pass", 32'(pass0), 32'(x[0]));
      end
    end
    if (done0 === 1'b1) begin
      done_cnt0++;
      pend0 = 1;
    end
  end

  bit pend1 = 0;
  always @(negedge clk) begin
    logic [8:0] y;
    if (pend1) begin
      pend1 = 0;
      check_eq("sb1_pending", 32'(sb1.size() > 0), 32'd1);
      if (sb1.size() > 0) begin
        y = sb1.pop_front();
        check_eq("sb1_result_tt", 32'(res1), 32'(y[8:5]));
        check_eq("sb1_mismatch", 32'(mm1), 32'(y[4:1]));
        check_eq("sb1_pass", 32'(pass1), 32'(y[0]));
      end
    end
    if (done1 === 1'b1) begin
      done_cnt1++;
      pend1 = 1;
    end
  end

  // Full sweep on the settle-2 instance; optionally change exp_tt after the start edge
  task automatic run_sweep0(input logic [3:0] e, input bit is_or, input bit chg_exp);
    logic [8:0] x;
    x = sweep_expect(e, is_or);
    gate_or0 = is_or;
    @(negedge clk);
    start0 = 1'b1;
    exp0   = e;
    sb0.push_back(x);
    @(negedge clk);
    start0 = 1'b0;
    if (chg_exp) exp0 = 4'b0001;
    for (int j = 0; j < 8; j++) begin
      check_eq("sweep0_ab", 32'({a0, b0}), 32'(j / 2));
      check_eq("sweep0_busy", 32'(busy0), 32'd1);
      check_eq("sweep0_done_early", 32'(done0), 32'd0);
      @(negedge clk);
    end
    check_eq("sweep0_done_latency", 32'(done0), 32'd1);
    check_eq("sweep0_ab_done", 32'({a0, b0, busy0}), 32'd0);
    @(negedge clk);
    check_eq("sweep0_done_width", 32'(done0), 32'd0);
    last_res0  = x[8:5];
    last_mm0   = x[4:1];
    last_pass0 = x[0];
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; exp0 = '0; gate_or0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; exp1 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_outputs0", 32'({a0, b0, busy0, done0, pass0, res0, mm0, aborted0}), 32'd0);
    check_eq("rst_outputs1", 32'({a1, b1, busy1, done1, pass1, res1, mm1, aborted1}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AND gate, AND table then OR table
    run_sweep0(4'b1000, 1'b0, 1'b0);
    run_sweep0(4'b1110, 1'b0, 1'b0);

    // Abort on the third SETTLE cycle (vector 01)
    dc = done_cnt0;
    @(negedge clk);
    start0 = 1'b1; exp0 = 4'b1000;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_vec01", 32'({a0, b0}), 32'd1);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check_eq("abort_pulse", 32'(aborted0), 32'd1);
    check_eq("abort_ab_busy", 32'({a0, b0, busy0}), 32'd0);
    check_eq("abort_keep_res", 32'(res0), 32'(last_res0));
    check_eq("abort_keep_mm", 32'(mm0), 32'(last_mm0));
    check_eq("abort_keep_pass", 32'(pass0), 32'(last_pass0));
    @(negedge clk);
    check_eq("abort_pulse_width", 32'(aborted0), 32'd0);
    repeat (12) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt0), 32'(dc));

    // start and abort together in IDLE
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    check_eq("start_abort_busy", 32'(busy0), 32'd0);
    check_eq("start_abort_aborted", 32'(aborted0), 32'd0);
    @(negedge clk);
    check_eq("start_abort_busy2", 32'({busy0, a0, b0}), 32'd0);

    // exp_tt changed after the start edge: latched value is used
    run_sweep0(4'b1000, 1'b0, 1'b1);

    // Reset during vector 10
    dc = done_cnt0;
    @(negedge clk);
    start0 = 1'b1; exp0 = 4'b1000;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_mid_vec10", 32'({a0, b0}), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_outputs", 32'({a0, b0, busy0, done0, pass0, res0, mm0, aborted0}), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("rst_mid_no_done", 32'(done_cnt0), 32'(dc));

    // OR gate on the settle-1 instance with a second start during the sweep
    dc = done_cnt1;
    @(negedge clk);
    start1 = 1'b1; exp1 = 4'b1110;
    sb1.push_back(sweep_expect(4'b1110, 1'b1));
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check_eq("sweep1_ab", 32'({a1, b1}), 32'(j));
      check_eq("sweep1_busy", 32'(busy1), 32'd1);
      start1 = (j == 1);
      @(negedge clk);
    end
    start1 = 1'b0;
    check_eq("sweep1_done_latency", 32'(done1), 32'd1);
    repeat (10) @(negedge clk);
    check_eq("sweep1_one_done", 32'(done_cnt1), 32'(dc + 1));
    check_eq("sweep1_idle", 32'(busy1), 32'd0);

    check_eq("sb0_drained", 32'(sb0.size()), 32'd0);
    check_eq("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
